d16_intc: RTL
=============

Name: d16_intc

Overview:
- Interrupt controller sitting directly upstream of the d16 core; drives the core's 3-bit `i_int` input.
- Collects 7 edge-triggered sources, with per-source enable and pending registers.
- Presents the highest-priority pending vector to the core and holds it until software signals end-of-interrupt.
- Returns `o_int` to 0 for a guaranteed gap, so the core's 0-to-nonzero detector re-arms.
- Register file is a wishbone-style slave on the core's `cyc`/`we` bus; no ack; reads are same-cycle combinational.

Parameters:
- GAP_CYCLES, 2, minimum number of cycles `o_int` is held at 0 after an EOI before a new vector may be presented. Legal range 2..15.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_irq  input  7  interrupt sources; bit k maps to vector k+1.
- i_wb_addr  input  2  register select (address decoded externally).
- i_wb_cyc  input  1  access strobe (chip select already qualified).
- i_wb_we  input  1  write enable.
- i_wb_dat  input  16  write data.
- o_wb_dat  output  16  read data, combinational from registers.
- o_int  output  3  vector to core; 0 = no interrupt.

Behaviour:
- Register map (bits 15:7 read 0):
  - 0 PENDING: R, write-1-to-clear.
  - 1 ENABLE: R/W.
  - 2 STATUS/EOI: read returns {busy at bit 3, active vector at 2:0}; any write = EOI.
  - 3 SWSET: write-1-to-set pending; reads 0.
- Edge detect:
  - prev_irq register sampled every cycle.
  - pending[k] is set at the edge where i_irq[k]=1 and prev_irq[k]=0.
  - A set wins over a simultaneous W1C clear or EOI clear of the same bit.
  - Level high without a new edge does not re-set pending.
- Priority: highest index wins among (PENDING & ENABLE); vector = index+1.
- FSM, registered, encoding in package:
  - IDLE: o_int=0. If any pending&enabled, latch vector into `active` and go to PRESENT. o_int is valid the cycle after the pending bit is visible.
  - PRESENT: o_int=active, stable. Disabling or clearing the source does not withdraw the vector. A write to EOI clears pending[active-1] (unless a new edge coincides), then go to GAP.
  - GAP: o_int=0; counter loads GAP_CYCLES-1 and counts down; at 0 go to IDLE.
- Latency: source edge before edge E → pending=1 after E → o_int nonzero after E+1.
- EOI written in IDLE or GAP: ignored.
- Reset:
  - Outputs: o_int=0.
  - Registers: PENDING=0, ENABLE=0, active=0, prev_irq=0.
  - FSM: state=IDLE, gap counter=0.
  - Reset asserted mid-PRESENT drops o_int to 0 on the next edge.
- Read while i_wb_cyc=0: o_wb_dat=0.

Optional Feature:
- Macro: D16_INTC_SYNC_EN.
- Defined: 2-flop synchronizer on i_irq ahead of the edge detector; latency increases by 2 cycles (o_int nonzero after E+3).
- Undefined: i_irq is used directly and assumed synchronous to i_clk.

Decomposition:
- Package d16_intc_pkg:
  - register address constants (PENDING, ENABLE, STATUS, SWSET);
  - FSM state encoding (IDLE, PRESENT, GAP);
  - NUM_IRQ=7;
  - vector width=3.
- Sub-module d16_prio_enc: combinational 7-to-3 highest-index encoder with a valid flag.
- Everything else stays in d16_intc.

Test Plan:
- Basic path:
  - Stimulus: ENABLE=0x7F, pulse i_irq[2].
  - Required: PENDING=0x04 after 1 edge; o_int=3 after 2 edges; STATUS reads 0x000B; o_int stays 3 until EOI.
- Priority:
  - Stimulus: ENABLE=0x7F, i_irq[0] and i_irq[5] rise in the same cycle.
  - Required: o_int=6. After EOI: o_int=0 for exactly 2 cycles, then o_int=1.
- Masking:
  - Stimulus: ENABLE=0x00, edge on i_irq[4].
  - Required: PENDING=0x10, o_int stays 0. Then write ENABLE=0x10 → o_int=5 one cycle later.
- Collisions:
  - Stimulus: in PRESENT with vector 2, write EOI in the same cycle as a new edge on i_irq[1].
  - Required: PENDING bit 1 stays 1; GAP lasts 2 cycles; o_int=2 again.
  - Stimulus: SWSET=0x40 in the same cycle as W1C PENDING=0x40.
  - Required: bit 6 ends set.
- Reset mid-operation:
  - Stimulus: in PRESENT (o_int=7), assert i_reset for 1 cycle.
  - Required: o_int=0, PENDING=0, ENABLE=0 next cycle; subsequent edges are not presented until ENABLE is written.
- Held level:
  - Stimulus: i_irq[3] held high through EOI.
  - Required: no re-trigger; o_int stays 0 after GAP until i_irq[3] falls and rises again.

Source files
------------

// File: rtl/d16_intc_pkg.sv
// Shared constants for the d16 interrupt controller: register map, widths and FSM encoding.
package d16_intc_pkg;

  localparam int NUM_IRQ = 7;
  localparam int VEC_W   = 3;
  localparam int GAP_W   = 4;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_SWSET   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } state_e;

endpackage

// File: rtl/d16_intc_if.sv
// Register bus between the d16 core and the interrupt controller (no ack, combinational read).
interface d16_intc_if;
  import d16_intc_pkg::*;

  logic [1:0]  i_wb_addr;
  logic        i_wb_cyc;
  logic        i_wb_we;
  logic [15:0] i_wb_dat;
  logic [15:0] o_wb_dat;

  modport master (
    output i_wb_addr, i_wb_cyc, i_wb_we, i_wb_dat,
    input  o_wb_dat
  );

  modport slave (
    input  i_wb_addr, i_wb_cyc, i_wb_we, i_wb_dat,
    output o_wb_dat
  );

endinterface

// File: rtl/d16_prio_enc.sv
// Combinational highest-index-wins encoder; returns index+1 so that 0 means "nothing requested".
module d16_prio_enc
  import d16_intc_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req_i,
  output logic [VEC_W-1:0]   vec_o,
  output logic               valid_o
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    vec_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (req_i[i]) begin
        vec_o   = VEC_W'(i + 1);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/d16_intc.sv
// Interrupt controller feeding the d16 core's i_int; presents one vector until EOI, then a zero gap.
// Optional macro D16_INTC_SYNC_EN inserts a 2-flop synchronizer on i_irq.
module d16_intc
  import d16_intc_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_IRQ-1:0] i_irq,
  d16_intc_if.slave          bus,
  output logic [VEC_W-1:0]   o_int
);

  logic [NUM_IRQ-1:0] irqSrc;
  logic [NUM_IRQ-1:0] prevIrq_q;
  logic [NUM_IRQ-1:0] irqEdge;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] eoiMask;
  logic [VEC_W-1:0]   active_q, active_d;
  logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;
  state_e             state_q, state_d;
  logic [VEC_W-1:0]   prioVec;
  logic               prioValid;
  logic               wbWr;
  logic               eoiWr;
  logic               eoiAccept;
  logic [15:0]        rdData;
  logic               unusedDat;

`ifdef D16_INTC_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_irq;
      sync2_q <= sync1_q;
    end
  end

  assign irqSrc = sync2_q;
`else
  assign irqSrc = i_irq;
`endif

  assign irqEdge   = irqSrc & ~prevIrq_q;
  assign wbWr      = bus.i_wb_cyc & bus.i_wb_we;
  assign eoiWr     = wbWr && (bus.i_wb_addr == ADDR_STATUS);
  assign eoiAccept = eoiWr && (state_q == ST_PRESENT);
  assign eoiMask   = NUM_IRQ'(1) << (active_q - VEC_W'(1));
  assign unusedDat = ^bus.i_wb_dat[15:NUM_IRQ];

  d16_prio_enc u_prio (
    .req_i   (pending_q & enable_q),
    .vec_o   (prioVec),
    .valid_o (prioValid)
  );

  // New edges are OR-ed in last so they survive a same-cycle W1C or EOI clear.
  always_comb begin
    pending_d = pending_q;
    enable_d  = enable_q;
    if (eoiAccept) begin
      pending_d = pending_d & ~eoiMask;
    end
    if (wbWr && (bus.i_wb_addr == ADDR_PENDING)) begin
      pending_d = pending_d & ~bus.i_wb_dat[NUM_IRQ-1:0];
    end
    if (wbWr && (bus.i_wb_addr == ADDR_SWSET)) begin
      pending_d = pending_d | bus.i_wb_dat[NUM_IRQ-1:0];
    end
    if (wbWr && (bus.i_wb_addr == ADDR_ENABLE)) begin
      enable_d = bus.i_wb_dat[NUM_IRQ-1:0];
    end
    pending_d = pending_d | irqEdge;
  end

  // When the gap expires with work waiting, present directly so the zero gap is exactly GAP_CYCLES.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    gapCnt_d = gapCnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (prioValid) begin
          active_d = prioVec;
          state_d  = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (eoiWr) begin
          gapCnt_d = GAP_W'(GAP_CYCLES - 1);
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gapCnt_q == '0) begin
          if (prioValid) begin
            active_d = prioVec;
            state_d  = ST_PRESENT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gapCnt_d = gapCnt_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      active_q  <= '0;
      gapCnt_q  <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      prevIrq_q <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      gapCnt_q  <= gapCnt_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      prevIrq_q <= irqSrc;
    end
  end

  assign o_int = (state_q == ST_PRESENT) ? active_q : '0;

  always_comb begin
    rdData = '0;
    if (bus.i_wb_cyc) begin
      unique case (bus.i_wb_addr)
        ADDR_PENDING: rdData = 16'(pending_q);
        ADDR_ENABLE:  rdData = 16'(enable_q);
        ADDR_STATUS:  rdData = 16'({(state_q != ST_IDLE), active_q});
        default:      rdData = '0;
      endcase
    end
  end

  assign bus.o_wb_dat = rdData;

endmodule
